// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target model.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam logic        I2C_ACK    = 1'b0;
  localparam logic        I2C_NACK   = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WR,
    S_WR_ACK,
    S_RD,
    S_RD_ACK,
    S_IGNORE
  } i2c_tgt_state_e;

  // True for states where the ninth (acknowledge) clock is in progress.
  function automatic logic is_ack_state(input i2c_tgt_state_e s);
    return (s == S_ADDR_ACK) || (s == S_PTR_ACK) || (s == S_WR_ACK) || (s == S_RD_ACK);
  endfunction

endpackage

// File: rtl/i2c_target_model_if.sv
// Bus-side signal bundle of the I2C target: resolved SCL/SDA in, open-drain and status out.
interface i2c_target_model_if #(
  parameter int unsigned MEM_DEPTH = 16
);
  localparam int unsigned PTR_W = $clog2(MEM_DEPTH);

  logic             scl_i;
  logic             sda_i;
  logic             sda_oe;
  logic             busy;
  logic             addr_hit;
  logic             wr_valid;
  logic [PTR_W-1:0] wr_addr;
  logic [7:0]       wr_data;
  logic             rd_valid;
  logic             bus_err;

  modport slave (
    input  scl_i, sda_i,
    output sda_oe, busy, addr_hit, wr_valid, wr_addr, wr_data, rd_valid, bus_err
  );

  modport master (
    output scl_i, sda_i,
    input  sda_oe, busy, addr_hit, wr_valid, wr_addr, wr_data, rd_valid, bus_err
  );
endinterface

// File: rtl/i2c_bus_sampler.sv
// Synchronizes SCL/SDA into clk and produces registered edge, START and STOP strobes.
module i2c_bus_sampler #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o,
  output logic sda_s_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_h_q;
  logic                   sda_h_q;
  logic                   scl_s;
  logic                   sda_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Synchronizer chain, one-flop history and aligned strobe registers (bus idles high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_h_q     <= 1'b1;
      sda_h_q     <= 1'b1;
      scl_rise_o  <= 1'b0;
      scl_fall_o  <= 1'b0;
      start_det_o <= 1'b0;
      stop_det_o  <= 1'b0;
      sda_s_o     <= 1'b1;
    end else begin
      scl_sync_q  <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q  <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_h_q     <= scl_s;
      sda_h_q     <= sda_s;
      scl_rise_o  <= scl_s & ~scl_h_q;
      scl_fall_o  <= ~scl_s & scl_h_q;
      start_det_o <= scl_s & scl_h_q & sda_h_q & ~sda_s;
      stop_det_o  <= scl_s & scl_h_q & ~sda_h_q & sda_s;
      sda_s_o     <= sda_s;
    end
  end

endmodule

// File: rtl/i2c_target_model.sv
// I2C target backed by a small byte register file with an auto-incrementing pointer.
module i2c_target_model
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h50,
  parameter int unsigned           MEM_DEPTH   = 16,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter logic [7:0]            MEM_INIT    = 8'h00
) (
  input  logic                pclk,
  input  logic                prst,
  i2c_target_model_if.slave   bus
);

  localparam int unsigned PTR_W = $clog2(MEM_DEPTH);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_sampler (
    .clk         (pclk),
    .rst         (prst),
    .scl_i       (bus.scl_i),
    .sda_i       (bus.sda_i),
    .scl_rise_o  (scl_rise),
    .scl_fall_o  (scl_fall),
    .start_det_o (start_det),
    .stop_det_o  (stop_det),
    .sda_s_o     (sda_s)
  );

  i2c_tgt_state_e   state_q;
  logic [2:0]       bitcnt_q;
  logic             hi_q;
  logic             rw_q;
  logic [7:0]       shreg_q;
  logic [PTR_W-1:0] ptr_q;
  logic [7:0]       mem_q [MEM_DEPTH];
  logic             sda_oe_q, busy_q, addr_hit_q, wr_valid_q, rd_valid_q, bus_err_q;
  logic [PTR_W-1:0] wr_addr_q;
  logic [7:0]       wr_data_q;

  logic [7:0]       byte_c;
  logic [PTR_W-1:0] ptr_inc_c;
  logic             addr_ok_c;

  assign byte_c    = {shreg_q[6:0], sda_s};
  assign ptr_inc_c = ptr_q + PTR_W'(1);
  // General call and 10-bit prefixes are never claimed.
  assign addr_ok_c = (byte_c[7:1] == TARGET_ADDR) && (byte_c[7:1] != 7'h00) &&
                     (byte_c[7:3] != 5'b11110);

  assign bus.sda_oe   = sda_oe_q;
  assign bus.busy     = busy_q;
  assign bus.addr_hit = addr_hit_q;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.bus_err  = bus_err_q;

  // Protocol FSM; hi_q marks that the current bit has seen its SCL rise, so bitcnt_q
  // counts completed bits and a repeated START's own SCL rise is not a partial byte.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_q    <= S_IDLE;
      bitcnt_q   <= 3'd0;
      hi_q       <= 1'b0;
      rw_q       <= 1'b0;
      shreg_q    <= 8'h00;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      addr_hit_q <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      bus_err_q  <= 1'b0;
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem_q[PTR_W'(i)] <= MEM_INIT;
    end else begin
      addr_hit_q <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_valid_q <= 1'b0;
      bus_err_q  <= 1'b0;
      if (start_det || stop_det) begin
        if ((bitcnt_q != 3'd0) || is_ack_state(state_q)) bus_err_q <= 1'b1;
        bitcnt_q <= 3'd0;
        hi_q     <= 1'b0;
        sda_oe_q <= 1'b0;
        state_q  <= start_det ? S_ADDR : S_IDLE;
        busy_q   <= start_det;
      end else begin
        unique case (state_q)
          S_ADDR, S_PTR, S_WR: begin
            if (scl_rise) begin
              if (bitcnt_q == 3'd7) begin
                bitcnt_q <= 3'd0;
                hi_q     <= 1'b0;
                if (state_q == S_ADDR) begin
                  if (addr_ok_c) begin
                    state_q    <= S_ADDR_ACK;
                    addr_hit_q <= 1'b1;
                    rw_q       <= byte_c[0];
                  end else begin
                    state_q <= S_IGNORE;
                  end
                end else if (state_q == S_PTR) begin
                  ptr_q   <= byte_c[PTR_W-1:0];
                  state_q <= S_PTR_ACK;
                end else begin
                  mem_q[ptr_q] <= byte_c;
                  wr_valid_q   <= 1'b1;
                  wr_addr_q    <= ptr_q;
                  wr_data_q    <= byte_c;
                  ptr_q        <= ptr_inc_c;
                  state_q      <= S_WR_ACK;
                end
              end else begin
                shreg_q <= byte_c;
                hi_q    <= 1'b1;
              end
            end else if (scl_fall && hi_q) begin
              bitcnt_q <= bitcnt_q + 3'd1;
              hi_q     <= 1'b0;
            end
          end
          S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
            // First fall pulls SDA low, second fall ends the ACK clock.
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else if ((state_q == S_ADDR_ACK) && rw_q) begin
                shreg_q    <= mem_q[ptr_q];
                sda_oe_q   <= ~mem_q[ptr_q][7];
                rd_valid_q <= 1'b1;
                state_q    <= S_RD;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= (state_q == S_ADDR_ACK) ? S_PTR : S_WR;
              end
            end
          end
          S_RD: begin
            if (scl_rise) begin
              hi_q <= 1'b1;
            end else if (scl_fall) begin
              if (!hi_q) begin
                sda_oe_q <= ~shreg_q[7];
              end else if (bitcnt_q == 3'd7) begin
                hi_q     <= 1'b0;
                bitcnt_q <= 3'd0;
                sda_oe_q <= 1'b0;
                state_q  <= S_RD_ACK;
              end else begin
                hi_q     <= 1'b0;
                bitcnt_q <= bitcnt_q + 3'd1;
                shreg_q  <= {shreg_q[6:0], 1'b0};
                sda_oe_q <= ~shreg_q[6];
              end
            end
          end
          S_RD_ACK: begin
            if (scl_rise) begin
              ptr_q <= ptr_inc_c;
              if (sda_s == I2C_NACK) begin
                state_q <= S_IGNORE;
              end else begin
                shreg_q    <= mem_q[ptr_inc_c];
                rd_valid_q <= 1'b1;
                state_q    <= S_RD;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
